wb_initiator: RTL and testbench



---
 rtl/wb_initiator_pkg.sv | 23 ++
 rtl/wb_initiator_if.sv | 29 ++
 rtl/wb_initiator_timer.sv | 38 +++
 rtl/wb_initiator.sv | 175 +++++++++++++++++
 tb/tb_wb_initiator.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_initiator_pkg.sv
// Shared types and constants for the Wishbone B4 initiator.
// State encoding, response status codes and a counter-width helper.
package wb_initiator_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStrobe,
    StWaitAck,
    StBackoff,
    StResp
  } wb_state_e;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ERR     = 2'b01;
  localparam logic [1:0] ST_RTY     = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/wb_initiator_if.sv
// Pipelined Wishbone B4 bus bundle between one initiator and one responder.
// The initiator drives the request side; the responder drives data and terminations.
interface wb_initiator_if #(
  parameter int unsigned ADDR_WIDTH = 32
) ();

  logic                  cyc;
  logic                  stb;
  logic                  we;
  logic [ADDR_WIDTH-1:0] adr;
  logic [3:0]            sel;
  logic [31:0]           dat_w;
  logic [31:0]           dat_r;
  logic                  ack;
  logic                  err;
  logic                  rty;
  logic                  stall;

  modport master (
    output cyc, stb, we, adr, sel, dat_w,
    input  dat_r, ack, err, rty, stall
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_w,
    output dat_r, ack, err, rty, stall
  );

endinterface

// File: rtl/wb_initiator_timer.sv
// Loadable saturating down-counter used as the bus-cycle watchdog.
// expired_o flags the last enabled cycle before the count would reach zero.
module wb_initiator_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [Width-1:0] load_val_i,
  output logic             expired_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q == Width'(1));

endmodule

// File: rtl/wb_initiator.sv
// Wishbone B4 pipelined initiator: turns single-beat local commands into bus cycles,
// with bounded retry on rty and a watchdog timeout, returning one response per command.
module wb_initiator
  import wb_initiator_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,

  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [31:0]           cmd_dat_i,
  input  logic [3:0]            cmd_sel_i,

  output logic                  rsp_valid_o,
  output logic [31:0]           rsp_dat_o,
  output logic [1:0]            rsp_status_o,

  wb_initiator_if.master        wb
);

  localparam int unsigned TW = cnt_width(TIMEOUT);
  localparam int unsigned RW = cnt_width(MAX_RETRY);

  wb_state_e             state_q;
  logic                  cyc_q, stb_q, we_q;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [3:0]            sel_q;
  logic [31:0]           dat_q;
  logic [RW-1:0]         retry_q;
  logic                  rsp_valid_q;
  logic [31:0]           rsp_dat_q;
  logic [1:0]            rsp_status_q;

  logic                  bus_live;
  logic                  term;
  logic                  tmo;
  logic                  retry_ok;
  logic                  fin;
  logic                  backoff;
  logic [1:0]            fin_status;
  logic [31:0]           fin_dat;
  logic                  tmr_expired;
  logic [TW-1:0]         tmr_load_val;

  assign tmr_load_val = TW'(TIMEOUT);

  // Timer reloads while idle or backing off, so every attempt gets a fresh budget.
  wb_initiator_timer #(
    .Width (TW)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .clr_i      (state_q == StResp),
    .load_i     ((state_q == StIdle) || (state_q == StBackoff)),
    .en_i       (bus_live),
    .load_val_i (tmr_load_val),
    .expired_o  (tmr_expired)
  );

  // Terminations only count once the request is accepted (stall low) or pending.
  always_comb begin
    bus_live   = (state_q == StStrobe) || (state_q == StWaitAck);
    term       = bus_live && ((state_q == StWaitAck) || !wb.stall) &&
                 (wb.ack || wb.err || wb.rty);
    tmo        = bus_live && (TIMEOUT != 0) && tmr_expired;
    retry_ok   = 32'(retry_q) < MAX_RETRY;
    fin        = 1'b0;
    backoff    = 1'b0;
    fin_status = ST_OK;
    fin_dat    = '0;
    if (term) begin
      if (wb.err) begin
        fin        = 1'b1;
        fin_status = ST_ERR;
      end else if (wb.rty) begin
        if (retry_ok) begin
          backoff = 1'b1;
        end else begin
          fin        = 1'b1;
          fin_status = ST_RTY;
        end
      end else begin
        fin        = 1'b1;
        fin_status = ST_OK;
        fin_dat    = we_q ? 32'h0 : wb.dat_r;
      end
    end else if (tmo) begin
      fin        = 1'b1;
      fin_status = ST_TIMEOUT;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= StIdle;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      sel_q        <= '0;
      dat_q        <= '0;
      retry_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_dat_q    <= '0;
      rsp_status_q <= ST_OK;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (cmd_valid_i) begin
            we_q    <= cmd_we_i;
            adr_q   <= cmd_adr_i;
            dat_q   <= cmd_dat_i;
            sel_q   <= cmd_sel_i;
            retry_q <= '0;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            state_q <= StStrobe;
          end
        end
        StStrobe, StWaitAck: begin
          if (fin) begin
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            rsp_valid_q  <= 1'b1;
            rsp_status_q <= fin_status;
            rsp_dat_q    <= fin_dat;
            state_q      <= StResp;
          end else if (backoff) begin
            retry_q <= retry_q + 1'b1;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            state_q <= StBackoff;
          end else if ((state_q == StStrobe) && !wb.stall) begin
            stb_q   <= 1'b0;
            state_q <= StWaitAck;
          end
        end
        StBackoff: begin
          cyc_q   <= 1'b1;
          stb_q   <= 1'b1;
          state_q <= StStrobe;
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          cyc_q   <= 1'b0;
          stb_q   <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign cmd_ready_o  = (state_q == StIdle) && rst_n_i;

  assign wb.cyc       = cyc_q;
  assign wb.stb       = stb_q;
  assign wb.we        = we_q;
  assign wb.adr       = adr_q;
  assign wb.sel       = sel_q;
  assign wb.dat_w     = dat_q;

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_dat_o    = rsp_dat_q;
  assign rsp_status_o = rsp_status_q;

endmodule

// File: tb/tb_wb_initiator.sv
// Directed self-checking bench for wb_initiator (TIMEOUT=8, MAX_RETRY=3).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_wb_initiator;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic [31:0] rsp_dat;
  logic [1:0]  rsp_status;

  int n_cmp = 0;
  int n_bad = 0;

  wb_initiator_if #(.ADDR_WIDTH(32)) wb ();

  wb_initiator #(
    .ADDR_WIDTH (32),
    .TIMEOUT    (8),
    .MAX_RETRY  (3)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_we_i     (cmd_we),
    .cmd_adr_i    (cmd_adr),
    .cmd_dat_i    (cmd_dat),
    .cmd_sel_i    (cmd_sel),
    .rsp_valid_o  (rsp_valid),
    .rsp_dat_o    (rsp_dat),
    .rsp_status_o (rsp_status),
    .wb           (wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, required finish before 100000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a command and return just after the accepting edge.
  task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
    int n = 0;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 10) begin
      step();
      n++;
    end
    check("issue_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
  endtask

  // Responder: no stall, answers rty for the first n_rty attempts then ack (or never).
  // Returns at the cycle rsp_valid is seen, or when the budget runs out.
  task automatic serve(input int n_rty, input bit never, input int budget,
                       output int attempts, output int min_gap, output int max_gap,
                       output int cyc_hi, output bit got);
    bit prev_stb = 1'b0;
    int gap = 0;
    attempts = 0;
    min_gap  = 1000;
    max_gap  = 0;
    cyc_hi   = 0;
    got      = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
      if (wb.stb && !prev_stb) begin
        attempts++;
        if (attempts > 1) begin
          if (gap < min_gap) min_gap = gap;
          if (gap > max_gap) max_gap = gap;
        end
        gap = 0;
      end
      if (wb.cyc) cyc_hi++;
      else gap++;
      prev_stb = wb.stb;
      wb.ack = 1'b0;
      wb.err = 1'b0;
      wb.rty = 1'b0;
      if (!never && wb.cyc && !wb.stb) begin
        if (attempts <= n_rty) wb.rty = 1'b1;
        else wb.ack = 1'b1;
      end
      step();
    end
    wb.ack = 1'b0;
    wb.err = 1'b0;
    wb.rty = 1'b0;
  endtask

  int attempts, min_gap, max_gap, cyc_hi, pulses, bad;
  bit got;

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = '0;
    cmd_dat   = '0;
    cmd_sel   = '0;
    wb.dat_r  = '0;
    wb.ack    = 1'b0;
    wb.err    = 1'b0;
    wb.rty    = 1'b0;
    wb.stall  = 1'b0;

    // Reset state
    repeat (3) step();
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_cyc", wb.cyc, 0);
    check("rst_stb", wb.stb, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_status", rsp_status, 0);
    rst_n = 1'b1;
    #1;
    check("rst_release_ready", cmd_ready, 1);

    // Write, zero stall, ack one cycle after stb
    wb.dat_r = 32'hFFFF_FFFF;
    issue(1'b1, 32'h0, 32'h1234_5678, 4'hF);
    check("t1_stb", wb.stb, 1);
    check("t1_cyc", wb.cyc, 1);
    check("t1_we", wb.we, 1);
    check("t1_dat_w", wb.dat_w, 32'h1234_5678);
    check("t1_sel", wb.sel, 4'hF);
    check("t1_ready_busy", cmd_ready, 0);
    step();
    check("t1_stb_one_cycle", wb.stb, 0);
    check("t1_cyc_wait", wb.cyc, 1);
    wb.ack = 1'b1;
    step();
    wb.ack = 1'b0;
    check("t1_rsp_valid", rsp_valid, 1);
    check("t1_rsp_status", rsp_status, 2'b00);
    check("t1_rsp_dat", rsp_dat, 32'h0);
    check("t1_cyc_drop", wb.cyc, 0);
    step();
    check("t1_rsp_pulse_end", rsp_valid, 0);
    check("t1_ready_again", cmd_ready, 1);

    // Read with three stalled cycles, then ack
    wb.stall = 1'b1;
    issue(1'b0, 32'h4, 32'h0, 4'hF);
    for (int i = 0; i < 4; i++) begin
      check("t2_stb_held", wb.stb, 1);
      check("t2_adr_stable", wb.adr, 32'h4);
      wb.stall = (i < 3);
      step();
    end
    check("t2_stb_released", wb.stb, 0);
    check("t2_cyc_wait", wb.cyc, 1);
    wb.ack   = 1'b1;
    wb.dat_r = 32'hDEAD_BEEF;
    step();
    wb.ack = 1'b0;
    check("t2_rsp_valid", rsp_valid, 1);
    check("t2_rsp_dat", rsp_dat, 32'hDEAD_BEEF);
    check("t2_rsp_status", rsp_status, 2'b00);
    step();
    check("t2_rsp_pulse_end", rsp_valid, 0);
    check("t2_rsp_dat_hold", rsp_dat, 32'hDEAD_BEEF);

    // Read terminated by err and ack together: err wins
    wb.dat_r = 32'hCAFE_F00D;
    issue(1'b0, 32'h8, 32'h0, 4'h3);
    step();
    wb.err = 1'b1;
    wb.ack = 1'b1;
    step();
    wb.err = 1'b0;
    wb.ack = 1'b0;
    check("t3_rsp_status", rsp_status, 2'b01);
    check("t3_rsp_dat", rsp_dat, 32'h0);
    pulses = int'(rsp_valid);
    repeat (3) begin
      step();
      if (rsp_valid) pulses++;
    end
    check("t3_one_pulse", pulses, 1);

    // Two rty then ack
    wb.dat_r = 32'h55AA_55AA;
    issue(1'b0, 32'h10, 32'h0, 4'hF);
    serve(2, 1'b0, 40, attempts, min_gap, max_gap, cyc_hi, got);
    check("t4_got", got, 1);
    check("t4_attempts", attempts, 3);
    check("t4_min_gap", min_gap, 1);
    check("t4_max_gap", max_gap, 1);
    check("t4_status", rsp_status, 2'b00);
    check("t4_dat", rsp_dat, 32'h55AA_55AA);

    // rty on every attempt: retries exhausted
    issue(1'b0, 32'h14, 32'h0, 4'hF);
    serve(4, 1'b0, 40, attempts, min_gap, max_gap, cyc_hi, got);
    check("t5_got", got, 1);
    check("t5_attempts", attempts, 4);
    check("t5_max_gap", max_gap, 1);
    check("t5_status", rsp_status, 2'b10);
    check("t5_dat", rsp_dat, 32'h0);

    // Responder never answers: timeout after 8 bus cycles
    issue(1'b1, 32'h18, 32'hA5A5_A5A5, 4'hF);
    serve(0, 1'b1, 40, attempts, min_gap, max_gap, cyc_hi, got);
    check("t6_got", got, 1);
    check("t6_cyc_cycles", cyc_hi, 8);
    check("t6_attempts", attempts, 1);
    check("t6_status", rsp_status, 2'b11);
    check("t6_dat", rsp_dat, 32'h0);

    // Following command completes normally
    wb.dat_r = 32'h1357_2468;
    issue(1'b0, 32'h1C, 32'h0, 4'hF);
    serve(0, 1'b0, 40, attempts, min_gap, max_gap, cyc_hi, got);
    check("t7_got", got, 1);
    check("t7_attempts", attempts, 1);
    check("t7_status", rsp_status, 2'b00);
    check("t7_dat", rsp_dat, 32'h1357_2468);

    // Ack in the accepting cycle is honoured immediately
    step();
    issue(1'b1, 32'h20, 32'h0000_0001, 4'h1);
    wb.ack = 1'b1;
    step();
    wb.ack = 1'b0;
    check("t8_rsp_valid", rsp_valid, 1);
    check("t8_status", rsp_status, 2'b00);

    // rty beats ack: one backoff, then a clean retry
    step();
    issue(1'b0, 32'h24, 32'h0, 4'hF);
    step();
    wb.rty = 1'b1;
    wb.ack = 1'b1;
    step();
    wb.rty = 1'b0;
    wb.ack = 1'b0;
    check("t9_backoff_cyc", wb.cyc, 0);
    check("t9_no_rsp", rsp_valid, 0);
    serve(0, 1'b0, 40, attempts, min_gap, max_gap, cyc_hi, got);
    check("t9_got", got, 1);
    check("t9_attempts", attempts, 1);
    check("t9_status", rsp_status, 2'b00);

    // Reset pulse during WAIT_ACK
    step();
    issue(1'b0, 32'h28, 32'h0, 4'hF);
    step();
    check("t10_in_wait", wb.cyc, 1);
    rst_n = 1'b0;
    step();
    check("t10_cyc", wb.cyc, 0);
    check("t10_stb", wb.stb, 0);
    check("t10_rsp_valid", rsp_valid, 0);
    check("t10_ready_in_rst", cmd_ready, 0);
    rst_n = 1'b1;
    #1;
    check("t10_ready_after", cmd_ready, 1);
    wb.ack = 1'b1;
    wb.err = 1'b1;
    bad = 0;
    repeat (3) begin
      step();
      if (rsp_valid || wb.cyc) bad++;
    end
    wb.ack = 1'b0;
    wb.err = 1'b0;
    check("t10_stray_ignored", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
